// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
//   Buffered echo path between a UART receiver and transmitter. Received
//   bytes are queued in a DEPTH-entry FIFO and replayed to the transmitter
//   one at a time, only while it is idle. A transform chosen by 'mode' is
//   applied when each byte leaves the FIFO.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   rx_valid      1-cycle strobe: rx_data holds a received byte
//   rx_data       received byte
//   rx_error      receiver framing error strobe
//   tx_busy       transmitter is shifting a byte out
//   tx_start      1-cycle strobe: start transmitting tx_data
//   tx_data       byte to transmit; held until the next pop
//   mode          0 pass, 1 XOR with xor_key, 2 ASCII upper-case, 3 hold
//   xor_key       key for mode 1
//   fifo_count    current FIFO occupancy
//   overflow      sticky: a byte arrived while the FIFO was full
//   drop_count    saturating count of dropped bytes (overflow or TX timeout)
//   err_count     saturating count of rx_error strobes

module uart_echo_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 64,
    parameter int ERR_W        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_error,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic [1:0]                 mode,
    input  logic [DATA_W-1:0]          xor_key,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [ERR_W-1:0]           drop_count,
    output logic [ERR_W-1:0]           err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_XOR   = 2'd1;
    localparam logic [1:0] MODE_UPPER = 2'd2;
    localparam logic [1:0] MODE_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [TW-1:0]     timer;

    logic full, empty;
    logic pop, push_ok, ovf_drop, timed_out;
    logic [1:0] drop_inc;

    function automatic logic [DATA_W-1:0] xform(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        m,
        input logic [DATA_W-1:0] k
    );
        logic [DATA_W-1:0] r;
        r = d;
        case (m)
            MODE_XOR:   r = d ^ k;
            MODE_UPPER: if (d >= DATA_W'(8'h61) && d <= DATA_W'(8'h7A))
                            r = d - DATA_W'(8'h20);
            default:    r = d;
        endcase
        return r;
    endfunction

    assign full  = (fifo_count == CW'(DEPTH));
    assign empty = (fifo_count == '0);

    // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
    assign push_ok  = rx_valid && !rx_error && (!full || pop);
    assign ovf_drop = rx_valid && !rx_error && full && !pop;

    // Both drop sources can fire on the same edge, so increment by up to two.
    assign drop_inc = {1'b0, ovf_drop} + {1'b0, timed_out};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (pop)       state_nxt = S_LOAD;
            S_LOAD:                     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy)   state_nxt = S_WAIT_DONE;
                         else if (timed_out) state_nxt = S_IDLE;
            S_WAIT_DONE: if (!tx_busy)  state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Mode is only consulted in IDLE, so a switch to hold lets the byte
    // already in flight finish.
    always_comb begin
        pop       = 1'b0;
        timed_out = 1'b0;
        tx_start  = 1'b0;
        case (state)
            S_IDLE:      pop       = !empty && (mode != MODE_HOLD) && !tx_busy;
            S_LOAD:      tx_start  = 1'b1;
            S_WAIT_BUSY: timed_out = !tx_busy && (timer == TW'(BUSY_TIMEOUT - 1));
            default:     ;
        endcase
    end

    // Timer counts cycles spent in WAIT_BUSY; cleared everywhere else.
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT_BUSY) timer <= '0;
        else if (!tx_busy)               timer <= timer + TW'(1);
    end

    // ---------------- FIFO storage ----------------
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_data    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                tx_data <= xform(mem[rd_ptr], mode, xor_key);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- status and counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            err_count  <= '0;
        end else begin
            if (ovf_drop) overflow <= 1'b1;

            if (drop_inc != 2'd0) begin
                if (drop_count > ({ERR_W{1'b1}} - ERR_W'(drop_inc)))
                    drop_count <= {ERR_W{1'b1}};
                else
                    drop_count <= drop_count + ERR_W'(drop_inc);
            end

            if (rx_error && err_count != {ERR_W{1'b1}})
                err_count <= err_count + ERR_W'(1);
        end
    end

    // MODE_PASS is the default transform arm; referenced here for clarity only.
    logic unused_mode_pass;
    assign unused_mode_pass = (MODE_PASS == 2'd0);

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed self-checking bench for uart_echo_fifo (default parameters).
// A small UART model raises tx_busy for five cycles after each tx_start;
// it can be disabled so the bench drives tx_busy directly.

module tb_uart_echo_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_error = 1'b0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] mode = 2'd0;
    logic [7:0] xor_key = 8'h00;
    logic [4:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_count;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;

    logic       uart_en = 1'b1;
    logic       force_busy = 1'b0;
    logic [2:0] model_cnt = 3'd0;
    int         cyc = 0;

    logic [7:0] tx_q[$];
    int         tx_cyc[$];

    uart_echo_fifo dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_error(rx_error), .tx_busy(tx_busy), .tx_start(tx_start),
        .tx_data(tx_data), .mode(mode), .xor_key(xor_key),
        .fifo_count(fifo_count), .overflow(overflow),
        .drop_count(drop_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    assign tx_busy = uart_en ? (model_cnt != 3'd0) : force_busy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!uart_en)             model_cnt <= 3'd0;
        else if (tx_start)        model_cnt <= 3'd5;
        else if (model_cnt != 0)  model_cnt <= model_cnt - 3'd1;
    end

    always @(negedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            tx_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx_q.delete();
        tx_cyc.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int limit);
        for (int i = 0; i < limit && tx_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        uart_en = 1'b1; mode = 2'd0;
        do_reset();
        checks++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || fifo_count !== 5'd0 ||
            overflow !== 1'b0 || drop_count !== 8'd0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset: start=%b data=%h cnt=%0d ovf=%b drop=%0d err=%0d, want all 0",
                     tx_start, tx_data, fifo_count, overflow, drop_count, err_count);
        end
    endtask

    task automatic test_single();
        uart_en = 1'b1; mode = 2'd0;
        do_reset();
        push_byte(8'h41);
        checks++;
        if (fifo_count !== 5'd1 || tx_start !== 1'b0) begin
            failures++;
            $display("FAIL single_write: cnt=%0d start=%b, want 1 0", fifo_count, tx_start);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
            failures++;
            $display("FAIL single_latency: start=%b data=%h, want 1 41", tx_start, tx_data);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (tx_q.size() != 1 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL single_once: pulses=%0d drop=%0d, want 1 0", tx_q.size(), drop_count);
        end
    endtask

    task automatic test_overflow();
        uart_en = 1'b0; force_busy = 1'b1; mode = 2'd0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'h10 + 8'(i);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (fifo_count !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd4 || tx_q.size() != 0) begin
            failures++;
            $display("FAIL overflow: cnt=%0d ovf=%b drop=%0d pulses=%0d, want 16 1 4 0",
                     fifo_count, overflow, drop_count, tx_q.size());
        end
        uart_en = 1'b1;
        wait_tx(16, 400);
        repeat (10) @(negedge clk);
        checks++;
        if (tx_q.size() != 16 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL drain_count: pulses=%0d cnt=%0d, want 16 0", tx_q.size(), fifo_count);
        end
        for (int i = 0; i < 16 && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== 8'h10 + 8'(i)) begin
                failures++;
                $display("FAIL drain_order[%0d]: got %h want %h", i, tx_q[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_transform();
        logic [7:0] din [5];
        logic [7:0] dexp[5];
        logic [1:0] dm  [5];
        din[0] = 8'h0F; dm[0] = 2'd1; dexp[0] = 8'hF0;
        din[1] = 8'h7A; dm[1] = 2'd2; dexp[1] = 8'h5A;
        din[2] = 8'h7B; dm[2] = 2'd2; dexp[2] = 8'h7B;
        din[3] = 8'h61; dm[3] = 2'd2; dexp[3] = 8'h41;
        din[4] = 8'h60; dm[4] = 2'd2; dexp[4] = 8'h60;
        uart_en = 1'b1; xor_key = 8'hFF;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mode = dm[i];
            tx_q.delete();
            push_byte(din[i]);
            wait_tx(1, 30);
            repeat (10) @(negedge clk);
            checks++;
            if (tx_q.size() != 1 || tx_q[0] !== dexp[i]) begin
                failures++;
                $display("FAIL xform[%0d]: pulses=%0d got %h want %h", i, tx_q.size(),
                         (tx_q.size() > 0) ? tx_q[0] : 8'hxx, dexp[i]);
            end
        end
        mode = 2'd0;
    endtask

    task automatic test_hold();
        uart_en = 1'b1; mode = 2'd3;
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
        repeat (20) @(negedge clk);
        checks++;
        if (tx_q.size() != 0 || fifo_count !== 5'd5) begin
            failures++;
            $display("FAIL hold: pulses=%0d cnt=%0d, want 0 5", tx_q.size(), fifo_count);
        end
        mode = 2'd0;
        wait_tx(5, 150);
        checks++;
        if (tx_q.size() != 5) begin
            failures++;
            $display("FAIL hold_release: pulses=%0d want 5", tx_q.size());
        end
        for (int i = 0; i < 5 && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== 8'hA0 + 8'(i)) begin
                failures++;
                $display("FAIL hold_order[%0d]: got %h want %h", i, tx_q[i], 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_errors();
        uart_en = 1'b1; mode = 2'd0;
        do_reset();
        @(negedge clk);
        rx_valid = 1'b1; rx_error = 1'b1; rx_data = 8'h55;
        repeat (10) @(negedge clk);
        checks++;
        if (err_count !== 8'd10 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL err_mid: err=%0d cnt=%0d, want 10 0", err_count, fifo_count);
        end
        repeat (290) @(negedge clk);
        rx_valid = 1'b0; rx_error = 1'b0;
        @(negedge clk);
        checks++;
        if (err_count !== 8'd255 || fifo_count !== 5'd0 || drop_count !== 8'd0 ||
            overflow !== 1'b0 || tx_q.size() != 0) begin
            failures++;
            $display("FAIL err_sat: err=%0d cnt=%0d drop=%0d ovf=%b pulses=%0d, want 255 0 0 0 0",
                     err_count, fifo_count, drop_count, overflow, tx_q.size());
        end
    endtask

    task automatic test_timeout();
        int gap;
        uart_en = 1'b0; force_busy = 1'b0; mode = 2'd0;
        do_reset();
        push_byte(8'h31);
        push_byte(8'h32);
        wait_tx(2, 200);
        checks++;
        if (tx_q.size() != 2) begin
            failures++;
            $display("FAIL timeout_next: pulses=%0d want 2", tx_q.size());
        end else begin
            gap = tx_cyc[1] - tx_cyc[0];
            checks++;
            if (gap < 64 || gap > 68 || tx_q[0] !== 8'h31 || tx_q[1] !== 8'h32) begin
                failures++;
                $display("FAIL timeout_gap: gap=%0d bytes=%h %h, want 64..68 31 32",
                         gap, tx_q[0], tx_q[1]);
            end
        end
        checks++;
        if (drop_count !== 8'd1) begin
            failures++;
            $display("FAIL timeout_drop: drop=%0d want 1", drop_count);
        end
    endtask

    task automatic test_reset_mid();
        uart_en = 1'b0; force_busy = 1'b0; mode = 2'd0;
        do_reset();
        push_byte(8'h77);
        push_byte(8'h78);
        push_byte(8'h79);
        wait_tx(1, 20);
        force_busy = 1'b1;
        repeat (4) @(negedge clk);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || fifo_count !== 5'd0 ||
            overflow !== 1'b0 || drop_count !== 8'd0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid: start=%b data=%h cnt=%0d ovf=%b drop=%0d err=%0d, want all 0",
                     tx_start, tx_data, fifo_count, overflow, drop_count, err_count);
        end
        tx_q.delete();
        force_busy = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (tx_q.size() != 0) begin
            failures++;
            $display("FAIL reset_discard: pulses=%0d want 0", tx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_transform();
        test_hold();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
